compare_arbiter: RTL and testbench

- Shares a single magnitude comparator between NREQ requesters; each requester submits an operand pair (A, B) and receives a 2-bit relation code.
- Arbitration is round-robin, so every requester is eventually served.
- Sits between client blocks and the comparator datapath. Serializes requests with valid/ready handshakes and returns the code tagged with the requester id.

---
 rtl/compare_pkg.sv | 17 +
 rtl/compare_core.sv | 35 +++
 rtl/compare_arbiter.sv | 137 +++++++++++++
 tb/tb_compare_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/compare_pkg.sv
// Shared definitions for the compare_arbiter slice.
//   - Relation code constants returned on rsp_code.
//   - FSM state type used by compare_arbiter.
package compare_pkg;

  localparam logic [1:0] CMP_NONE = 2'b00;
  localparam logic [1:0] CMP_EQ   = 2'b01;
  localparam logic [1:0] CMP_GT   = 2'b10;
  localparam logic [1:0] CMP_LT   = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCmp  = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/compare_core.sv
// Combinational W-bit magnitude comparator.
// Build option: COMPARE_SIGNED_EN selects two's-complement comparison; when
// undefined the operands are compared as unsigned.
// Ports:
//   a_i    - operand A
//   b_i    - operand B
//   code_o - relation code (CMP_EQ, CMP_GT or CMP_LT; never CMP_NONE)
module compare_core
  import compare_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [1:0]   code_o
);

  logic a_gt_b;

`ifdef COMPARE_SIGNED_EN
  assign a_gt_b = $signed(a_i) > $signed(b_i);
`else
  assign a_gt_b = a_i > b_i;
`endif

  always_comb begin
    code_o = CMP_LT;
    if (a_i == b_i) begin
      code_o = CMP_EQ;
    end else if (a_gt_b) begin
      code_o = CMP_GT;
    end
  end

endmodule

// File: rtl/compare_arbiter.sv
// Round-robin arbiter sharing one magnitude comparator among NREQ requesters.
// A request is accepted in IDLE, compared in CMP and presented in RESP until
// the downstream accepts it. Build option COMPARE_SIGNED_EN (see compare_core)
// switches to signed comparison; ports and timing are unchanged.
// Ports:
//   clk, rst_n - clock (rising edge) and asynchronous active-low reset
//   req_valid  - per-requester request valid
//   req_a/b    - packed operands, requester i at [i*W +: W]
//   req_ready  - one-hot accept strobe (combinational, IDLE only)
//   rsp_valid  - result valid
//   rsp_id     - requester owning the result
//   rsp_code   - relation code, CMP_NONE when no result
//   rsp_ready  - downstream accepts the result
module compare_arbiter
  import compare_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 4,
  localparam int unsigned IdW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [IdW-1:0]    rsp_id,
  output logic [1:0]        rsp_code,
  input  logic              rsp_ready
);

  state_e         state_q, state_d;
  logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0] gnt_q, gnt_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [1:0]     code_q, code_d;
  logic [IdW-1:0] id_q, id_d;

  logic [W-1:0]   a_arr [NREQ];
  logic [W-1:0]   b_arr [NREQ];
  logic           grant_found;
  logic [IdW-1:0] grant_idx;
  logic [1:0]     core_code;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*W +: W];
    assign b_arr[i] = req_b[i*W +: W];
  end

  // Search upward starting one past the last served requester.
  always_comb begin
    int unsigned    idx;
    logic [IdW-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    cand        = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx  = (32'(rr_ptr_q) + k) % NREQ;
      cand = IdW'(idx);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  compare_core #(
    .W (W)
  ) u_core (
    .a_i    (a_q),
    .b_i    (b_q),
    .code_o (core_code)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt_q;
    a_d       = a_q;
    b_d       = b_q;
    code_d    = code_q;
    id_d      = id_q;
    req_ready = '0;
    case (state_q)
      StIdle: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          a_d                  = a_arr[grant_idx];
          b_d                  = b_arr[grant_idx];
          gnt_d                = grant_idx;
          state_d              = StCmp;
        end
      end
      StCmp: begin
        code_d  = core_code;
        id_d    = gnt_q;
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          code_d   = CMP_NONE;
          rr_ptr_d = gnt_q;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= IdW'(NREQ - 1);
      gnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      code_q   <= CMP_NONE;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      code_q   <= code_d;
      id_q     <= id_d;
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign rsp_code  = code_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_compare_arbiter.sv
// Self-checking bench for compare_arbiter: directed phases plus randomized
// traffic, checked by a scoreboard fed from a transaction-level model.
module tb_compare_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 4;
  localparam int unsigned IDW  = $clog2(NREQ);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [1:0]        rsp_code;
  logic              rsp_ready = 1'b0;

  compare_arbiter #(
    .NREQ (NREQ),
    .W    (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_code  (rsp_code),
    .rsp_ready (rsp_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int         id;
    logic [1:0] code;
  } exp_t;

  exp_t sb_q[$];
  int   grant_log[$];
  bit   busy = 1'b0;
  int   age = 0;
  int   last_ptr = NREQ - 1;
  bit   acc_seen = 1'b0;
  int   acc_id = 0;
  bit   drop_on_grant = 1'b1;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Relation from the numeric values of the operands.
  function automatic logic [1:0] ref_code(input logic [W-1:0] a, input logic [W-1:0] b);
    longint va;
    longint vb;
    va = longint'(a);
    vb = longint'(b);
`ifdef COMPARE_SIGNED_EN
    if (a[W-1]) va = va - (longint'(1) << W);
    if (b[W-1]) vb = vb - (longint'(1) << W);
`endif
    if (va == vb) return 2'b01;
    if (va > vb) return 2'b10;
    return 2'b11;
  endfunction

  // Monitor: predicts grants from the round-robin rule, pushes the expected
  // result on acceptance and pops/compares when the result is handed off.
  always @(negedge clk) begin : mon
    bit              was_busy;
    bit              done;
    int              exp_g;
    int              idx;
    logic [NREQ-1:0] exp_rdy;
    acc_seen = 1'b0;
    if (!rst_n) begin
      busy     = 1'b0;
      age      = 0;
      last_ptr = NREQ - 1;
      sb_q.delete();
    end else begin
      was_busy = busy;
      done     = 1'b0;
      if (was_busy) age++;
      check("rsp_valid", longint'(rsp_valid), longint'(was_busy && age >= 2));
      if (rsp_valid) begin
        check("sb_depth", sb_q.size(), 1);
        if (sb_q.size() > 0) begin
          check("rsp_id", longint'(rsp_id), sb_q[0].id);
          check("rsp_code", longint'(rsp_code), longint'(sb_q[0].code));
          if (rsp_ready) done = 1'b1;
        end
      end else begin
        check("idle_code", longint'(rsp_code), 0);
      end
      if (was_busy) begin
        check("ready_while_busy", longint'(req_ready), 0);
      end else begin
        exp_g = -1;
        for (int k = 1; k <= NREQ; k++) begin
          idx = (last_ptr + k) % NREQ;
          if (exp_g < 0 && req_valid[idx]) exp_g = idx;
        end
        exp_rdy = '0;
        if (exp_g >= 0) exp_rdy[exp_g] = 1'b1;
        check("grant", longint'(req_ready), longint'(exp_rdy));
        if (exp_g >= 0) begin
          sb_q.push_back('{exp_g, ref_code(req_a[exp_g*W +: W], req_b[exp_g*W +: W])});
          busy     = 1'b1;
          age      = 0;
          acc_seen = 1'b1;
          acc_id   = exp_g;
          grant_log.push_back(exp_g);
        end
      end
      if (done) begin
        last_ptr = sb_q[0].id;
        void'(sb_q.pop_front());
        busy = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (drop_on_grant && acc_seen) req_valid[acc_id] = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || (|req_valid)) && n < budget) begin
      step();
      n++;
    end
    check({name, "_timeout"}, longint'(busy || (|req_valid)), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, longint'(rsp_valid), 0);
    check({tag, "_rsp_code"}, longint'(rsp_code), 0);
    check({tag, "_rsp_id"}, longint'(rsp_id), 0);
    check({tag, "_req_ready"}, longint'(req_ready), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    // Reset, then ten idle cycles with nothing requested.
    repeat (3) step();
    check_reset_outputs("reset");
    rsp_ready = 1'b1;
    rst_n = 1'b1;
    repeat (10) step();

    // Single request from requester 0: 0 vs 1.
    grant_log.delete();
    req_a[0 +: W] = 4'b0000;
    req_b[0 +: W] = 4'b0001;
    req_valid[0] = 1'b1;
    drain("p2", 20);
    check("p2_grants", grant_log.size(), 1);
    if (grant_log.size() > 0) check("p2_grant0", grant_log[0], 0);

    // Requesters 1..3 together, each held until granted.
    grant_log.delete();
    req_a[1*W +: W] = 4'b1000;
    req_b[1*W +: W] = 4'b0001;
    req_a[2*W +: W] = 4'b0100;
    req_b[2*W +: W] = 4'b0100;
    req_a[3*W +: W] = 4'b1010;
    req_b[3*W +: W] = 4'b1001;
    req_valid = 4'b1110;
    drain("p3", 40);
    check("p3_grants", grant_log.size(), 3);
    for (int k = 0; k < grant_log.size() && k < 3; k++) check("p3_order", grant_log[k], k + 1);

    // All requesters held continuously for twelve grants.
    grant_log.delete();
    drop_on_grant = 1'b0;
    req_valid = '1;
    n = 0;
    while (grant_log.size() < 12 && n < 100) begin
      step();
      n++;
    end
    req_valid = '0;
    drop_on_grant = 1'b1;
    check("p4_grants", grant_log.size(), 12);
    for (int k = 0; k < grant_log.size() && k < 12; k++) check("p4_order", grant_log[k], k % NREQ);
    drain("p4", 20);

    // Backpressure: hold the result for five cycles while others wait.
    rsp_ready = 1'b0;
    req_valid[2] = 1'b1;
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    check("p5_rsp_seen", longint'(rsp_valid), 1);
    req_valid = '1;
    repeat (5) step();
    rsp_ready = 1'b1;
    drain("p5", 60);

    // Reset while the comparison of 1111 vs 1111 is in flight.
    req_a[0 +: W] = 4'b1111;
    req_b[0 +: W] = 4'b1111;
    req_valid[0] = 1'b1;
    n = 0;
    while (req_valid[0] && n < 10) begin
      step();
      n++;
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) step();
    rst_n = 1'b1;
    repeat (10) step();

    // Randomized traffic with random backpressure and early withdrawals.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        req_a[i*W +: W] = W'($urandom);
        req_b[i*W +: W] = ($urandom_range(0, 3) == 0) ? req_a[i*W +: W] : W'($urandom);
        if (!req_valid[i] && $urandom_range(0, 2) == 0) req_valid[i] = 1'b1;
        else if (req_valid[i] && $urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    drain("p7", 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
